// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**FIFO_DEPTH_BITS words of DATA_BITS each.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate occupancy counter. Read data is registered; a write
// into an empty FIFO is never bypassed to dataOut.
module sync_fifo #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [DATA_BITS-1:0] dataIn,
    output logic                 wfull,
    input  logic                 re,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 rempty,
    output logic                 busy
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int PW    = FIFO_DEPTH_BITS + 1;

    // Handshake: a read is accepted when re is high and the FIFO is not empty.
    // A write is accepted when we is high and the FIFO is not full, or when a
    // read is accepted in the same cycle (the read frees the slot the write fills).
    // Requests that are not accepted are dropped with no side effect.

    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];

    logic                 empty_c;
    logic                 full_c;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [FIFO_DEPTH_BITS-1:0] waddr;
    logic [FIFO_DEPTH_BITS-1:0] raddr;

    // Status flags and accept decisions, purely from the current pointers.
    always_comb begin
        waddr   = wptr_q[FIFO_DEPTH_BITS-1:0];
        raddr   = rptr_q[FIFO_DEPTH_BITS-1:0];
        empty_c = (wptr_q == rptr_q);
        full_c  = (waddr == raddr) && (wptr_q[PW-1] != rptr_q[PW-1]);
        rd_acc  = re && !empty_c;
        wr_acc  = we && (!full_c || rd_acc);
    end

    // Next-state for pointers, read data register and storage array.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        dout_d = dout_q;
        mem_d  = mem_q;
        if (wr_acc) begin
            mem_d[waddr] = dataIn;
            wptr_d       = wptr_q + PW'(1);
        end
        if (rd_acc) begin
            // Reads the pre-edge array, so on full+simultaneous write the
            // oldest word is returned, not the one being written.
            dout_d = mem_q[raddr];
            rptr_d = rptr_q + PW'(1);
        end
    end

    // Pointer and read-data registers; reset discards contents logically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= dout_d;
        end
    end

    // Storage array; not reset since empty pointers make old words unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Drive outputs from registered state.
    always_comb begin
        wfull   = full_c;
        rempty  = empty_c;
        busy    = !empty_c;
        dataOut = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: directed scenarios plus randomized traffic, all
// checked against a queue-based model of FIFO occupancy and read data.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DB    = 3;
    localparam int DEPTH = 1 << DB;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic          re;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          wfull;
    logic          rempty;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dout;

    sync_fifo #(.DATA_BITS(DW), .FIFO_DEPTH_BITS(DB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .dataIn (dataIn),
        .wfull  (wfull),
        .re     (re),
        .dataOut(dataOut),
        .rempty (rempty),
        .busy   (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // One clock cycle of requests; model updated from FIFO rules.
    task automatic do_cycle(input logic w, input logic r, input logic [DW-1:0] d);
        logic rd_ok;
        logic wr_ok;
        we     = w;
        re     = r;
        dataIn = d;
        @(posedge clk);
        rd_ok = r && (exp_q.size() != 0);
        wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout = '0;
    endtask

    task automatic test_reset();
        we = 0; re = 0; dataIn = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rempty !== 1'b1 || wfull !== 1'b0 || busy !== 1'b0 || dataOut !== 8'h00) begin
            n_err++;
            $display("FAIL reset: actual e=%b f=%b b=%b d=%h required e=1 f=0 b=0 d=00",
                     rempty, wfull, busy, dataOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 10; i++) begin
            do_cycle(1'b1, 1'b0, DW'(i));
            n_cmp++;
            if (wfull !== (i >= 8) || rempty !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL fill_%0d: actual f=%b e=%b b=%b required f=%b e=0 b=1",
                         i, wfull, rempty, busy, (i >= 8));
            end
        end
        n_cmp++;
        if (exp_q.size() != DEPTH || wfull !== 1'b1) begin
            n_err++;
            $display("FAIL fill_count: actual model=%0d f=%b required %0d f=1",
                     exp_q.size(), wfull, DEPTH);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] want;
        for (int i = 1; i <= 10; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            want = (i <= 8) ? DW'(i) : 8'h08;
            n_cmp++;
            if (dataOut !== want || dataOut !== exp_dout || rempty !== (i >= 8) ||
                busy !== (i < 8) || wfull !== 1'b0) begin
                n_err++;
                $display("FAIL drain_%0d: actual d=%h e=%b b=%b f=%b required d=%h e=%b b=%b f=0",
                         i, dataOut, rempty, busy, wfull, want, (i >= 8), (i < 8));
            end
        end
    endtask

    task automatic test_empty_we_re();
        do_cycle(1'b1, 1'b1, 8'h5A);
        n_cmp++;
        if (rempty !== 1'b0 || busy !== 1'b1 || dataOut !== 8'h08) begin
            n_err++;
            $display("FAIL empty_wr_rd: actual e=%b b=%b d=%h required e=0 b=1 d=08",
                     rempty, busy, dataOut);
        end
        do_cycle(1'b0, 1'b1, '0);
        n_cmp++;
        if (dataOut !== 8'h5A || rempty !== 1'b1) begin
            n_err++;
            $display("FAIL empty_wr_rd_read: actual d=%h e=%b required d=5a e=1", dataOut, rempty);
        end
    endtask

    task automatic test_full_we_re();
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, DW'(8'h10 + i));
        n_cmp++;
        if (wfull !== 1'b1) begin
            n_err++;
            $display("FAIL full_before: actual f=%b required f=1", wfull);
        end
        do_cycle(1'b1, 1'b1, 8'h18);
        n_cmp++;
        if (dataOut !== 8'h10 || wfull !== 1'b1 || rempty !== 1'b0) begin
            n_err++;
            $display("FAIL full_wr_rd: actual d=%h f=%b e=%b required d=10 f=1 e=0",
                     dataOut, wfull, rempty);
        end
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            n_cmp++;
            if (dataOut !== DW'(8'h11 + i) || rempty !== (i == 7) || wfull !== 1'b0) begin
                n_err++;
                $display("FAIL full_drain_%0d: actual d=%h e=%b f=%b required d=%h e=%b f=0",
                         i, dataOut, rempty, wfull, DW'(8'h11 + i), (i == 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, DW'(8'hA0 + i));
        do_cycle(1'b0, 1'b1, '0);
        n_cmp++;
        if (dataOut !== 8'hA0 || rempty !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pre: actual d=%h e=%b required d=a0 e=0", dataOut, rempty);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (rempty !== 1'b1 || busy !== 1'b0 || wfull !== 1'b0 || dataOut !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: actual e=%b b=%b f=%b d=%h required e=1 b=0 f=0 d=00",
                     rempty, busy, wfull, dataOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 1'b1, '0);
            n_cmp++;
            if (rempty !== 1'b1 || dataOut !== 8'h00) begin
                n_err++;
                $display("FAIL mid_read_%0d: actual e=%b d=%h required e=1 d=00", i, rempty, dataOut);
            end
        end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        int   bias;
        for (int i = 0; i < 600; i++) begin
            // Alternate phases that favour filling and draining to hit both ends.
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(99, 0) < bias);
            r = ($urandom_range(99, 0) < (100 - bias));
            do_cycle(w, r, DW'($urandom_range(255, 0)));
            n_cmp++;
            if (dataOut !== exp_dout || rempty !== (exp_q.size() == 0) ||
                wfull !== (exp_q.size() == DEPTH) || busy !== (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL random_%0d: actual d=%h e=%b f=%b b=%b required d=%h cnt=%0d",
                         i, dataOut, rempty, wfull, busy, exp_dout, exp_q.size());
            end
        end
    endtask

    // main sequence and final report
    initial begin
        rst_n  = 1'b0;
        we     = 1'b0;
        re     = 1'b0;
        dataIn = '0;
        exp_dout = '0;
        test_reset();
        test_fill();
        test_drain();
        test_empty_we_re();
        test_full_we_re();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
